bubble_outbuf_nch: RTL
======================

Name: bubble_outbuf_nch

Overview:
Parametrised successor to the two-channel bubble output path. Holds a double-buffered page image written bit-serially by the SPI loader, and replays it on NCH bubble data outputs (DOUT0..DOUT3 class) in step with the timing generator's cycle/tick stream. Adds channel-count generalisation, bank ping-pong with deferred flip, a channel-swap mode and an overrun flag.

Parameters:
NCH, 2, number of data output channels; legal 1, 2, 4.
CYCLES, 584, output cycles per page (bits per channel per page).
CNUM_W, 13, width of the BOUTCYCLENUM input.
ACTIVE_LOW, 1, 1 = idle DOUT high and a data '1' drives low; 0 = idle low, '1' drives high.

Ports:
MCLK  in  1  system clock (48 MHz).
nRST  in  1  synchronous active-low reset.
ACCTYPE  in  3  access type from the timing generator.
BOUTCYCLENUM  in  CNUM_W  current output cycle index.
BOUTTICKS  in  2  phase within the output cycle (0..3).
nSWAPEN  in  1  low = swap channel pairs (0<->1, 2<->3); ignored when NCH=1.
nOUTBUFWCLKEN  in  1  active-low write strobe, one bit per MCLK.
OUTBUFWADDR  in  AW  write address {cycle, channel}; AW = clog2(CYCLES)+clog2(NCH).
OUTBUFWDATA  in  1  write data bit.
BANKFLIP  in  1  single-cycle request to exchange load and play banks.
DOUT  out  NCH  bubble data outputs.
LOADBANK  out  1  bank currently written by the loader.
FLIPPEND  out  1  flip requested but deferred.
OVERRUN  out  1  sticky: cycle index out of range during a read.

Behaviour:
- Reset (nRST low at a MCLK edge): DOUT = all idle level; LOADBANK=0 (play bank 1); FLIPPEND=0; OVERRUN=0; internal read pipeline cleared. RAM contents are not reset. Reset mid-page aborts output immediately on the next edge.
- ACCTYPE codes (shared package): 3'b000 IDLE, 3'b001 BOOTRD, 3'b010 PAGERD; all others reserved and treated as IDLE.
- Write side: when nOUTBUFWCLKEN=0, bit OUTBUFWDATA is stored at OUTBUFWADDR in bank LOADBANK. Address cycle field >= CYCLES -> write dropped, no flag. Writes are accepted in every state.
- Bank flip: BANKFLIP=1 with ACCTYPE=IDLE -> LOADBANK toggles at that edge. BANKFLIP=1 while not IDLE -> FLIPPEND=1. The flip executes on the first edge where ACCTYPE is IDLE; FLIPPEND clears at that edge. A second request while pending is absorbed. A write in the same cycle as a flip goes to the pre-flip LOADBANK.
- Read FSM states: IDLE, FETCH, DRIVE, HOLD.
  IDLE -> FETCH when ACCTYPE in {BOOTRD, PAGERD} and BOUTTICKS=0.
  FETCH: registers RAM address {~LOADBANK, BOUTCYCLENUM}. If BOUTCYCLENUM >= CYCLES, set OVERRUN and force the fetched word to zero.
  DRIVE (BOUTTICKS=1): RAM data is valid (1-cycle read latency). DOUT[i] = active level if word[map(i)]=1, else idle.
  HOLD (BOUTTICKS=2): DOUT is held.
  BOUTTICKS=3: DOUT returns to idle, then the FSM goes to FETCH on the next tick 0 if still active, else to IDLE.
  ACCTYPE leaving the active set in any state -> DOUT idle and state IDLE at the next edge.
- Channel map: map(i)=i when nSWAPEN=1, otherwise i^1 for NCH>=2. nSWAPEN is sampled in FETCH only; mid-cycle changes take effect next cycle.
- OVERRUN is cleared only by reset or by an executed bank flip.
- Output latency: DOUT valid 1 MCLK after BOUTTICKS becomes 1; all outputs registered.

Decomposition:
- Package bubble_pkg: ACCTYPE codes, tick phase constants (TICK_FETCH=0, TICK_DRIVE=1, TICK_HOLD=2, TICK_REL=3), clog2 helper.
- Sub-module bubble_bank_ram: simple dual-port, 1-bit write with per-channel write enable decoded from the low address bits, NCH-bit synchronous read, depth 2*CYCLES. Inferred as NCH block-RAM slices.

Test Plan:
- NCH=2, load bank 0 with cycle 5 = {ch1=1, ch0=0}, flip while idle, PAGERD, step to cycle 5 -> DOUT=2'b01 (active-low ch1 low) during ticks 1-2, 2'b11 at tick 3.
- Same image, nSWAPEN=0 -> DOUT=2'b10 at cycle 5; toggling nSWAPEN at tick 1 has no effect until cycle 6.
- Assert BANKFLIP during PAGERD -> FLIPPEND=1 and LOADBANK unchanged; ACCTYPE->IDLE -> LOADBANK toggles and FLIPPEND=0 on the same edge.
- BOUTCYCLENUM=600 (>=584) in BOOTRD -> OVERRUN=1, DOUT idle for that cycle; flip clears OVERRUN.
- NCH=4, write to cycle 583 channel 3 and to cycle 584 (dropped) -> readback shows only ch3 at 583, and cycle 584 reads as zero with OVERRUN set.
- nRST low at tick 1 of an active cycle -> next edge DOUT=all 1s, LOADBANK=0, FLIPPEND=0; RAM data is preserved on the following read.

Source files
------------

// File: rtl/bubble_pkg.sv
// Shared constants for the bubble output path: access types, tick phases, read FSM states.
package bubble_pkg;

  localparam logic [2:0] ACC_IDLE   = 3'b000;
  localparam logic [2:0] ACC_BOOTRD = 3'b001;
  localparam logic [2:0] ACC_PAGERD = 3'b010;

  localparam logic [1:0] TICK_FETCH = 2'd0;
  localparam logic [1:0] TICK_DRIVE = 2'd1;
  localparam logic [1:0] TICK_HOLD  = 2'd2;
  localparam logic [1:0] TICK_REL   = 2'd3;

  typedef enum logic [1:0] {StIdle, StFetch, StDrive, StHold} rd_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/bubble_bank_ram.sv
// Two-bank page image: 1-bit writes into one channel slice, NCH-bit synchronous reads.
module bubble_bank_ram #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned Depth = 1168,
  parameter int unsigned AddrW = 11,
  parameter int unsigned ChW   = 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [ChW-1:0]   wch_i,
  input  logic             wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [NCH-1:0]   rdata_o
);

  for (genvar g = 0; g < NCH; g++) begin : g_slice
    logic mem [Depth];
    logic rd_q;

    // One independent slice per channel so each maps onto its own block RAM.
    always_ff @(posedge clk_i) begin
      if (we_i && (wch_i == ChW'(g))) mem[waddr_i] <= wdata_i;
      if (re_i) rd_q <= mem[raddr_i];
    end

    assign rdata_o[g] = rd_q;
  end

endmodule

// File: rtl/bubble_outbuf_nch.sv
// Bubble output buffer: double-buffered page image replayed on NCH data outputs.
module bubble_outbuf_nch
  import bubble_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned CYCLES     = 584,
  parameter int unsigned CNUM_W     = 13,
  parameter bit          ACTIVE_LOW = 1'b1,
  localparam int unsigned CHW       = clog2(NCH),
  localparam int unsigned AW        = clog2(CYCLES) + CHW
) (
  input  logic              MCLK,
  input  logic              nRST,
  input  logic [2:0]        ACCTYPE,
  input  logic [CNUM_W-1:0] BOUTCYCLENUM,
  input  logic [1:0]        BOUTTICKS,
  input  logic              nSWAPEN,
  input  logic              nOUTBUFWCLKEN,
  input  logic [AW-1:0]     OUTBUFWADDR,
  input  logic              OUTBUFWDATA,
  input  logic              BANKFLIP,
  output logic [NCH-1:0]    DOUT,
  output logic              LOADBANK,
  output logic              FLIPPEND,
  output logic              OVERRUN
);

  localparam int unsigned DEPTH = 2 * CYCLES;
  localparam int unsigned RAW   = clog2(DEPTH);
  localparam int unsigned CHW1  = (CHW == 0) ? 1 : CHW;
  localparam logic [NCH-1:0] IDLE_LVL = {NCH{ACTIVE_LOW}};

  rd_state_e      state_q, state_d;
  logic [NCH-1:0] dout_q, dout_d;
  logic           zero_q, zero_d;
  logic           swap_q, swap_d;
  logic           loadbank_q, flippend_q, overrun_q;

  logic           active, flip_go, rd_oor, ren, ovr_set;
  logic [AW-1:0]  wcyc;
  logic [CHW1-1:0] wch;
  logic           we;
  logic [RAW-1:0] waddr, raddr;
  logic [NCH-1:0] ram_rdata, word, mapped;

  assign active  = (ACCTYPE == ACC_BOOTRD) || (ACCTYPE == ACC_PAGERD);
  // Flips only execute while idle, so reads and bank changes never collide.
  assign flip_go = (BANKFLIP || flippend_q) && !active;

  // Write side: {cycle, channel} address, out-of-range cycles silently dropped.
  assign wcyc  = OUTBUFWADDR >> CHW;
  assign wch   = CHW1'(OUTBUFWADDR & AW'(NCH - 1));
  assign we    = !nOUTBUFWCLKEN && (wcyc < AW'(CYCLES));
  assign waddr = RAW'(wcyc) + (loadbank_q ? RAW'(CYCLES) : '0);

  // Read side always targets the bank the loader is not writing.
  assign rd_oor = BOUTCYCLENUM >= CNUM_W'(CYCLES);
  assign raddr  = rd_oor ? '0 : RAW'(BOUTCYCLENUM) + (loadbank_q ? '0 : RAW'(CYCLES));

  bubble_bank_ram #(
    .NCH  (NCH),
    .Depth(DEPTH),
    .AddrW(RAW),
    .ChW  (CHW1)
  ) u_ram (
    .clk_i  (MCLK),
    .we_i   (we),
    .waddr_i(waddr),
    .wch_i  (wch),
    .wdata_i(OUTBUFWDATA),
    .re_i   (ren),
    .raddr_i(raddr),
    .rdata_o(ram_rdata)
  );

  // Fetched word with out-of-range suppression and optional pair swap.
  always_comb begin
    word = zero_q ? '0 : ram_rdata;
    for (int i = 0; i < NCH; i++) begin
      int unsigned j;
      j = (swap_q && (NCH > 1)) ? (i ^ 1) : i;
      mapped[i] = word[j];
    end
  end

  // Read FSM next state and output level, stepped by the tick phase.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    zero_d  = zero_q;
    swap_d  = swap_q;
    ren     = 1'b0;
    ovr_set = 1'b0;
    if (!active) begin
      state_d = StIdle;
      dout_d  = IDLE_LVL;
    end else begin
      case (BOUTTICKS)
        TICK_FETCH: begin
          ren     = 1'b1;
          state_d = StFetch;
          dout_d  = IDLE_LVL;
          zero_d  = rd_oor;
          ovr_set = rd_oor;
          swap_d  = !nSWAPEN && (NCH > 1);
        end
        TICK_DRIVE: begin
          if (state_q == StFetch) begin
            state_d = StDrive;
            dout_d  = mapped ^ IDLE_LVL;
          end
        end
        TICK_HOLD: begin
          if (state_q == StDrive) state_d = StHold;
        end
        default: begin
          dout_d = IDLE_LVL;
          if (state_q != StIdle) state_d = StHold;
        end
      endcase
    end
  end

  // Read pipeline registers.
  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      state_q <= StIdle;
      dout_q  <= IDLE_LVL;
      zero_q  <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      zero_q  <= zero_d;
      swap_q  <= swap_d;
    end
  end

  // Bank ping-pong, deferred flip and sticky overrun.
  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      loadbank_q <= 1'b0;
      flippend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (flip_go) begin
      loadbank_q <= ~loadbank_q;
      flippend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (BANKFLIP) flippend_q <= 1'b1;
      if (ovr_set) overrun_q <= 1'b1;
    end
  end

  assign DOUT     = dout_q;
  assign LOADBANK = loadbank_q;
  assign FLIPPEND = flippend_q;
  assign OVERRUN  = overrun_q;

endmodule
